// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    // Fetch FSM: normal fetching, or parked after an illegal PC until reset
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: bubble beats load, load happens only when enabled.
import instruction_fetch_unit_pkg::*;

module if_id_register (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic               i_bubble,
    input  logic [INSTR_W-1:0] i_instruction,
    input  logic [ADDR_W-1:0]  i_pc_plus4,
    output logic [INSTR_W-1:0] o_instruction,
    output logic [ADDR_W-1:0]  o_pc_plus4,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instruction;
    logic [ADDR_W-1:0]  r_pc_plus4;
    logic               r_valid;

    // Capture the fetched word, insert a bubble, or hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
        end else if (i_bubble) begin
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
        end else if (i_enable) begin
            r_instruction <= i_instruction;
            r_pc_plus4    <= i_pc_plus4;
            r_valid       <= 1'b1;
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, fault FSM and IF/ID register.
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic [INSTR_W-1:0] imem_instruction,
    output logic [ADDR_W-1:0]  imem_address,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] if_id_instruction,
    output logic [ADDR_W-1:0]  if_id_pc_plus4,
    output logic               if_id_valid,
    output logic               fetch_fault
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_fault;

    logic [ADDR_W-1:0]  w_word_idx;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic               w_bad_pc;
    logic               w_bubble;
    logic               w_enable;

    assign w_word_idx   = {2'b00, r_pc[31:2]};
    assign w_pc_plus4   = r_pc + 32'd4;
    assign imem_address = w_word_idx;

    // A misaligned or out-of-range PC must never be handed to decode
    assign w_bad_pc = (r_pc[1:0] != 2'b00) || (w_word_idx >= 32'(IMEM_WORDS));

    // Any non-advancing, non-stalling case turns the IF/ID slot into a bubble
    assign w_bubble = (r_state == FAULT) || w_bad_pc || redirect_valid || flush;
    assign w_enable = !stall;

    // PC update and fault FSM; redirect outranks flush, flush outranks stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_bad_pc) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else if (redirect_valid) begin
                        r_pc <= redirect_target;
                    end else if (flush || !stall) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                FAULT: begin
                    r_fault <= 1'b1;
                end
                default: r_state <= FAULT;
            endcase
        end
    end

    if_id_register u_if_id (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (w_enable),
        .i_bubble      (w_bubble),
        .i_instruction (imem_instruction),
        .i_pc_plus4    (w_pc_plus4),
        .o_instruction (if_id_instruction),
        .o_pc_plus4    (if_id_pc_plus4),
        .o_valid       (if_id_valid)
    );

    assign pc          = r_pc;
    assign fetch_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed vector table plus randomized run against a behavioural fetch model.
module tb_instruction_fetch_unit;

    localparam int IMEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] imem_instruction;
    logic [31:0] imem_address;
    logic [31:0] pc;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;

    logic [31:0] mem [0:IMEM_WORDS-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_instruction = (imem_address < 32'(IMEM_WORDS)) ? mem[imem_address[6:0]] : 32'h0;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem_instruction  (imem_instruction),
        .imem_address      (imem_address),
        .pc                (pc),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .fetch_fault       (fetch_fault)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs [$];

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_edge(input logic r, input logic s, input logic f,
                              input logic rv, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pp4, input logic e_valid, input logic e_fault);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".imem_address"}, imem_address, e_pc >> 2);
        chk({tag, ".instr"}, if_id_instruction, e_instr);
        chk({tag, ".pc_plus4"}, if_id_pc_plus4, e_pp4);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
        chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, e_fault});
    endtask

    // Spec-level fetch rules, one edge at a time
    task automatic model_step(input logic r, input logic s, input logic f,
                              input logic rv, input logic [31:0] t);
        logic bubble;
        bubble = 1'b0;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        end else if (m_fault) begin
            bubble = 1'b1;
        end else if ((m_pc % 4) != 0 || (m_pc / 4) >= IMEM_WORDS) begin
            m_fault = 1'b1;
            bubble  = 1'b1;
        end else if (rv) begin
            m_pc   = t;
            bubble = 1'b1;
        end else if (f) begin
            m_pc   = m_pc + 4;
            bubble = 1'b1;
        end else if (!s) begin
            m_instr = mem[m_pc / 4];
            m_pp4   = m_pc + 4;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
        end
        if (bubble) begin
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic rv,
                                input logic [31:0] t, input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] pp, input logic v, input logic flt);
        vec_t x;
        x.rst = r; x.stall = s; x.flush = f; x.rv = rv; x.tgt = t;
        x.e_pc = p; x.e_instr = i; x.e_pp4 = pp; x.e_valid = v; x.e_fault = flt;
        return x;
    endfunction

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h8C25_0003;
        mem[1] = 32'h00A1_2820;
        mem[2] = 32'h00A1_2820;

        //          rst stl fl rv tgt            pc          instr          pp4         v  flt
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h0,         32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h4,   32'h8C25_0003, 32'h4,   1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h8,   32'h00A1_2820, 32'h8,   1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h8,   32'h00A1_2820, 32'h8,   1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h8,   32'h00A1_2820, 32'h8,   1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,   32'h8,   32'h00A1_2820, 32'h8,   1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'hC,   32'h00A1_2820, 32'hC,   1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 32'h40,  32'h40,  32'h0,         32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h44,  32'h1000_0010, 32'h44,  1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h1FC, 32'h1FC, 32'h0,         32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h200, 32'h1000_007F, 32'h200, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h200, 32'h0,         32'h0,   0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h0,         32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h4,   32'h8C25_0003, 32'h4,   1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,   32'h8,   32'h0,         32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h6,   32'h6,   32'h0,         32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h6,   32'h0,         32'h0,   0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 32'h40,  32'h6,   32'h0,         32'h0,   0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h10,  32'h6,   32'h0,         32'h0,   0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 32'h80,  32'h0,   32'h0,         32'h0,   0, 0));

        foreach (vecs[k]) begin
            drive_edge(vecs[k].rst, vecs[k].stall, vecs[k].flush, vecs[k].rv, vecs[k].tgt);
            check_all($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_instr,
                      vecs[k].e_pp4, vecs[k].e_valid, vecs[k].e_fault);
        end

        // Hand sequence: reset during a stall drops the redirect, first valid word one edge later
        drive_edge(0, 0, 0, 0, 32'h0);
        drive_edge(1, 1, 0, 1, 32'h100);
        check_all("rst_in_stall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive_edge(0, 0, 0, 0, 32'h0);
        check_all("first_after_rst", 32'h4, 32'h8C25_0003, 32'h4, 1'b1, 1'b0);

        // Randomized run against the model
        model_step(1, 0, 0, 0, 32'h0);
        drive_edge(1, 0, 0, 0, 32'h0);
        check_all("rand_rst", m_pc, m_instr, m_pp4, m_valid, m_fault);
        for (int n = 0; n < 400; n++) begin
            logic r, s, f, rv;
            logic [31:0] t;
            r  = ($urandom_range(0, 29) == 0);
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 7) == 0);
            rv = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       t = 32'($urandom_range(0, IMEM_WORDS * 4 - 1));
                1:       t = 32'(IMEM_WORDS * 4 - 4 - 4 * $urandom_range(0, 3));
                2:       t = $urandom;
                default: t = 32'($urandom_range(0, IMEM_WORDS - 1)) << 2;
            endcase
            model_step(r, s, f, rv, t);
            drive_edge(r, s, f, rv, t);
            check_all($sformatf("rand%0d", n), m_pc, m_instr, m_pp4, m_valid, m_fault);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
